// File: rtl/fp_wb_scoreboard.sv
// FP register file write-back sequencer: pending-write scoreboard with RAW/WAW issue stall,
// plus arbitration of the single FPR write port. Optional FP_BYPASS_EN forwards write data to issue.
module fp_wb_scoreboard #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [4:0]  issue_fs,
   input  logic [4:0]  issue_ft,
   input  logic        issue_use_ft,
   input  logic        issue_writes,
   input  logic [4:0]  issue_fd,
   output logic        issue_stall,
   input  logic        fpu_valid,
   input  logic [4:0]  fpu_reg,
   input  logic [31:0] fpu_data,
   output logic        fpu_ready,
   input  logic        mov_valid,
   input  logic [4:0]  mov_reg,
   input  logic [31:0] mov_data,
   output logic        mov_ready,
   output logic        fp_reg_write,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   output logic        byp1_valid,
   output logic        byp2_valid,
   output logic [31:0] byp_data
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [31:0]       pending, pending_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              mov_gnt, fpu_gnt, grant;
   logic              fs_haz, ft_haz, fd_haz, accept;
   logic              fs_byp, ft_byp;

   // Write-port arbitration: FPU has priority until the move/load path has lost MAX_WAIT cycles.
   always_comb begin
      mov_gnt = 1'b0;
      fpu_gnt = 1'b0;
      if (!rst) begin
         mov_gnt = mov_valid & (!fpu_valid | (wait_cnt == WAIT_MAX));
         fpu_gnt = fpu_valid & !mov_gnt;
      end
      grant = mov_gnt | fpu_gnt;
   end

   always_comb begin
      write_reg  = 5'd0;
      write_data = 32'd0;
      if (mov_gnt) begin
         write_reg  = mov_reg;
         write_data = mov_data;
      end else if (fpu_gnt) begin
         write_reg  = fpu_reg;
         write_data = fpu_data;
      end
   end

   assign fpu_ready    = fpu_gnt;
   assign mov_ready    = mov_gnt;
   assign fp_reg_write = grant;

`ifdef FP_BYPASS_EN
   // A source being written back this very cycle can take the write data instead of stalling.
   assign fs_byp     = grant & (write_reg == issue_fs);
   assign ft_byp     = grant & issue_use_ft & (write_reg == issue_ft);
   assign byp1_valid = issue_valid & fs_byp;
   assign byp2_valid = issue_valid & ft_byp;
   assign byp_data   = write_data;
`else
   assign fs_byp     = 1'b0;
   assign ft_byp     = 1'b0;
   assign byp1_valid = 1'b0;
   assign byp2_valid = 1'b0;
   assign byp_data   = 32'd0;
`endif

   assign fs_haz      = pending[issue_fs] & !fs_byp;
   assign ft_haz      = issue_use_ft & pending[issue_ft] & !ft_byp;
   assign fd_haz      = issue_writes & pending[issue_fd];
   assign issue_stall = rst | (issue_valid & (fs_haz | ft_haz | fd_haz));
   assign accept      = issue_valid & !issue_stall & issue_writes;

   // Clear before set so a same-index set wins.
   always_comb begin
      pending_nxt = pending;
      if (grant)  pending_nxt[write_reg] = 1'b0;
      if (accept) pending_nxt[issue_fd]  = 1'b1;
   end

   always_comb begin
      wait_nxt = '0;
      if (mov_valid && !mov_gnt)
         wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         wait_cnt <= '0;
      end else begin
         pending  <= pending_nxt;
         wait_cnt <= wait_nxt;
      end
   end

endmodule
